// File: rtl/sap_out_display_if.sv
// SAP-1 output-port bundle: bus/strobe inputs and the display/status outputs.
// The slave side is the output port itself; the master side drives the bus.
interface sap_out_display_if;
  logic [7:0] bus_i;
  logic       load_en_i;
  logic [7:0] out_reg_o;
  logic       busy_o;
  logic [6:0] seg_o;
  logic [3:0] an_o;

  modport master (
    output bus_i, load_en_i,
    input  out_reg_o, busy_o, seg_o, an_o
  );

  modport slave (
    input  bus_i, load_en_i,
    output out_reg_o, busy_o, seg_o, an_o
  );
endinterface

// File: rtl/sap_out_display.sv
// SAP-1 output register with sequential double-dabble BCD conversion and a
// 4-digit multiplexed 7-segment driver. Define SAP_OUT_SIGNED_EN for two's-complement display.
module sap_out_display #(
  parameter int REFRESH_W = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  sap_out_display_if.slave  io
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  localparam logic [3:0] CODE_BLANK = 4'hA;
  localparam logic [3:0] CODE_MINUS = 4'hB;

  state_t               state_q, state_d;
  logic [2:0]           iter_q;
  logic [7:0]           out_reg_q;
  logic [11:0]          bcd_q;
  logic [7:0]           src_q;
  logic [7:0]           mag;
  logic [3:0]           dig_q [4];
  logic [REFRESH_W-1:0] presc_q;
  logic [1:0]           idx_q, idx_d;
  logic [3:0]           an_q;
  logic [6:0]           seg_q;
  logic                 load;

  assign load = io.load_en_i;

  function automatic logic [11:0] dabble_adj(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int n = 0; n < 3; n++) begin
      if (r[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = r[n*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:       s = 7'h3F;
      4'd1:       s = 7'h06;
      4'd2:       s = 7'h5B;
      4'd3:       s = 7'h4F;
      4'd4:       s = 7'h66;
      4'd5:       s = 7'h6D;
      4'd6:       s = 7'h7D;
      4'd7:       s = 7'h07;
      4'd8:       s = 7'h7F;
      4'd9:       s = 7'h6F;
      CODE_MINUS: s = 7'h40;
      default:    s = 7'h00;
    endcase
    return s;
  endfunction

`ifdef SAP_OUT_SIGNED_EN
  logic signed [7:0] bus_s;
  logic              sign_q;
  assign bus_s = io.bus_i;
  // 0x80 negates to itself, which read unsigned is the desired 128
  assign mag = bus_s[7] ? 8'(-bus_s) : io.bus_i;
`else
  assign mag = io.bus_i;
`endif

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = CONV;
    end else begin
      case (state_q)
        CONV:    if (iter_q == 3'd7) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign idx_d = (&presc_q) ? idx_q + 2'd1 : idx_q;

  // Conversion scratch is pure data: fully rewritten on every load.
  always_ff @(posedge clk_i) begin
    if (load) begin
      bcd_q <= '0;
      src_q <= mag;
    end else if (state_q == CONV) begin
      {bcd_q, src_q} <= {dabble_adj(bcd_q)[10:0], src_q, 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      iter_q    <= '0;
      out_reg_q <= '0;
      dig_q[0]  <= 4'd0;
      dig_q[1]  <= CODE_BLANK;
      dig_q[2]  <= CODE_BLANK;
      dig_q[3]  <= CODE_BLANK;
`ifdef SAP_OUT_SIGNED_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (load) begin
        out_reg_q <= io.bus_i;
        iter_q    <= '0;
`ifdef SAP_OUT_SIGNED_EN
        sign_q    <= io.bus_i[7];
`endif
      end else if (state_q == CONV) begin
        iter_q <= iter_q + 3'd1;
      end
      // A load on the DONE edge pre-empts the update so the stale result never shows.
      if (state_q == DONE && !load) begin
        dig_q[0] <= bcd_q[3:0];
        dig_q[1] <= (bcd_q[11:8] == 4'd0 && bcd_q[7:4] == 4'd0) ? CODE_BLANK : bcd_q[7:4];
        dig_q[2] <= (bcd_q[11:8] == 4'd0) ? CODE_BLANK : bcd_q[11:8];
`ifdef SAP_OUT_SIGNED_EN
        dig_q[3] <= sign_q ? CODE_MINUS : CODE_BLANK;
`endif
      end
    end
  end

  // Scan: an and seg are registered from the same next index so they stay aligned.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= 4'b1110;
      seg_q   <= 7'h3F;
    end else begin
      presc_q <= presc_q + REFRESH_W'(1);
      idx_q   <= idx_d;
      an_q    <= ~(4'b0001 << idx_d);
      seg_q   <= seg_decode(dig_q[idx_d]);
    end
  end

  assign io.out_reg_o = out_reg_q;
  assign io.busy_o    = (state_q != IDLE);
  assign io.an_o      = an_q;
  assign io.seg_o     = seg_q;

endmodule

// File: tb/tb_sap_out_display.sv
// Randomized self-checking bench for sap_out_display against a decimal-arithmetic display model.
// Honours SAP_OUT_SIGNED_EN the same way as the design.
module tb_sap_out_display;
  localparam int RW = 2;

  logic clk = 1'b0;
  logic rstn;
  int   nvec = 0;
  int   nerr = 0;
  int   edges;
  int   cur_mag;
  bit   cur_neg;

  sap_out_display_if bus_if ();

  sap_out_display #(.REFRESH_W(RW)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .io     (bus_if.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] digit_seg(input int d);
    logic [6:0] tab [10];
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return tab[d];
  endfunction

  function automatic logic [6:0] exp_seg(input int pos);
    int h, t, o;
    h = cur_mag / 100;
    t = (cur_mag / 10) % 10;
    o = cur_mag % 10;
    case (pos)
      0:       return digit_seg(o);
      1:       return (h == 0 && t == 0) ? 7'h00 : digit_seg(t);
      2:       return (h == 0) ? 7'h00 : digit_seg(h);
      default: return cur_neg ? 7'h40 : 7'h00;
    endcase
  endfunction

  task automatic set_model(input logic [7:0] v);
`ifdef SAP_OUT_SIGNED_EN
    cur_neg = v[7];
    cur_mag = v[7] ? 256 - int'(v) : int'(v);
`else
    cur_neg = 1'b0;
    cur_mag = int'(v);
`endif
  endtask

  // Called at a negedge: scan position follows from edges since reset.
  task automatic sample_display(input string tag);
    int pos;
    pos = (edges >> RW) & 3;
    check({tag, "_an"}, 32'(bus_if.an_o), 32'(~(4'b0001 << pos) & 4'hF));
    check({tag, "_seg"}, 32'(bus_if.seg_o), 32'(exp_seg(pos)));
  endtask

  task automatic scan_display(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_display(tag);
    end
  endtask

  // restart_k > 0: second load lands on edge E<restart_k> of the first conversion.
  task automatic run_load(input logic [7:0] v, input int restart_k, input logic [7:0] v2);
    int  cnt;
    bit  done;
    logic [7:0] final_v;
    @(negedge clk);
    bus_if.bus_i = v;
    bus_if.load_en_i = 1'b1;
    @(negedge clk);
    bus_if.load_en_i = 1'b0;
    check("out_reg", 32'(bus_if.out_reg_o), 32'(v));
    cnt = 0;
    done = 1'b0;
    for (int j = 0; j < 40 && !done; j++) begin
      if (!bus_if.busy_o) begin
        done = 1'b1;
      end else begin
        cnt++;
        sample_display("hold");
        if (restart_k > 0 && j == restart_k - 1) begin
          bus_if.bus_i = v2;
          bus_if.load_en_i = 1'b1;
        end else begin
          bus_if.load_en_i = 1'b0;
        end
        @(negedge clk);
        if (restart_k > 0 && j == restart_k - 1)
          check("out_reg_restart", 32'(bus_if.out_reg_o), 32'(v2));
        bus_if.load_en_i = 1'b0;
      end
    end
    check("busy_len", cnt, (restart_k > 0) ? restart_k + 9 : 9);
    final_v = (restart_k > 0) ? v2 : v;
    set_model(final_v);
    @(negedge clk);
    scan_display("disp", 16);
  endtask

  initial begin
    logic [7:0] dir [8];
    logic [7:0] v, v2;
    int k;
    rstn = 1'b1;
    bus_if.bus_i = 8'h00;
    bus_if.load_en_i = 1'b0;
    set_model(8'h00);
    #3 rstn = 1'b0;
    #1;
    check("rst_out_reg", 32'(bus_if.out_reg_o), 32'h00);
    check("rst_busy", 32'(bus_if.busy_o), 32'h0);
    check("rst_an", 32'(bus_if.an_o), 32'hE);
    check("rst_seg", 32'(bus_if.seg_o), 32'h3F);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    scan_display("rst_scan", 20);

    dir = '{8'hFF, 8'h07, 8'h64, 8'h00, 8'h80, 8'h7F, 8'h0A, 8'h63};
    foreach (dir[i]) run_load(dir[i], 0, 8'h00);

    run_load(8'h2A, 4, 8'h05);
    run_load(8'h99, 9, 8'hC8);
    run_load(8'h11, 1, 8'hF6);

    // Asynchronous reset in the middle of a 0xC8 conversion.
    @(negedge clk);
    bus_if.bus_i = 8'hC8;
    bus_if.load_en_i = 1'b1;
    @(negedge clk);
    bus_if.load_en_i = 1'b0;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    set_model(8'h00);
    check("arst_out_reg", 32'(bus_if.out_reg_o), 32'h00);
    check("arst_busy", 32'(bus_if.busy_o), 32'h0);
    check("arst_an", 32'(bus_if.an_o), 32'hE);
    check("arst_seg", 32'(bus_if.seg_o), 32'h3F);
    @(negedge clk);
    rstn = 1'b1;
    scan_display("arst_scan", 24);
    check("arst_busy_after", 32'(bus_if.busy_o), 32'h0);

    for (int i = 0; i < 24; i++) begin
      v  = 8'($urandom);
      v2 = 8'($urandom);
      k  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 9) : 0;
      run_load(v, k, v2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog no finish by %0t", $time);
    $fatal(1);
  end
endmodule
